// File: rtl/keypad_entry_controller_if.sv
// keypad_entry_controller_if
//   Groups the keypad encoder handshake and the entered-time outputs of
//   keypad_entry_controller.  Clock and reset stay plain module ports.
//   slave  : the controller (consumes entry/encoder signals, drives time).
//   master : whatever drives the encoder side and reads the entered time.
//   With KEYPAD_BEEP_EN defined the BEEP signal is carried as well.
interface keypad_entry_controller_if;
    logic       ENTRY_EN;
    logic       CLEAR;
    logic [3:0] ENC_BCD;
    logic       ENC_LOAD_N;
    logic       ENC_EN_N;
    logic [3:0] MIN_TENS;
    logic [3:0] MIN_ONES;
    logic [3:0] SEC_TENS;
    logic [3:0] SEC_ONES;
    logic [2:0] DIGIT_CNT;
    logic       TIME_NZ;
    logic       KEY_ACK;
    logic       KEY_REJ;
`ifdef KEYPAD_BEEP_EN
    logic       BEEP;

    modport slave (
        input  ENTRY_EN, CLEAR, ENC_BCD, ENC_LOAD_N,
        output ENC_EN_N, MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES,
               DIGIT_CNT, TIME_NZ, KEY_ACK, KEY_REJ, BEEP
    );
    modport master (
        output ENTRY_EN, CLEAR, ENC_BCD, ENC_LOAD_N,
        input  ENC_EN_N, MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES,
               DIGIT_CNT, TIME_NZ, KEY_ACK, KEY_REJ, BEEP
    );
`else
    modport slave (
        input  ENTRY_EN, CLEAR, ENC_BCD, ENC_LOAD_N,
        output ENC_EN_N, MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES,
               DIGIT_CNT, TIME_NZ, KEY_ACK, KEY_REJ
    );
    modport master (
        output ENTRY_EN, CLEAR, ENC_BCD, ENC_LOAD_N,
        input  ENC_EN_N, MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES,
               DIGIT_CNT, TIME_NZ, KEY_ACK, KEY_REJ
    );
`endif
endinterface

// File: rtl/keypad_entry_controller.sv
// keypad_entry_controller
//   Enables the decimal-to-BCD keypad encoder, debounces presses seen on
//   ENC_LOAD_N/ENC_BCD, and shifts each accepted digit into a 4-digit
//   MM:SS cook-time register.  One digit per physical press.
// Ports:
//   CLK      : system clock, rising edge
//   RESET_N  : synchronous active-low reset
//   kif      : keypad_entry_controller_if.slave
//              in : ENTRY_EN, CLEAR, ENC_BCD[3:0], ENC_LOAD_N
//              out: ENC_EN_N, MIN_TENS/MIN_ONES/SEC_TENS/SEC_ONES[3:0],
//                   DIGIT_CNT[2:0], TIME_NZ, KEY_ACK, KEY_REJ, (BEEP)
// Parameters:
//   DEBOUNCE_CYCLES : stable samples required for press and for release
//   BEEP_CYCLES     : BEEP pulse length in clocks
// Optional feature macro: KEYPAD_BEEP_EN (adds BEEP output and its counter).
module keypad_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BEEP_CYCLES     = 8
) (
    input  logic CLK,
    input  logic RESET_N,
    keypad_entry_controller_if.slave kif
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, RELEASE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    cand, cand_nx;
    logic          commit;

    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] digit_cnt;
    logic       key_ack, key_rej;
    logic       accept, reject;

    // Next-state logic.  The counter does double duty: stable-press samples
    // in DEBOUNCE, consecutive-high samples in RELEASE.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        commit   = 1'b0;
        if (!kif.ENTRY_EN) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!kif.ENC_LOAD_N) begin
                        cand_nx  = kif.ENC_BCD;
                        cnt_nx   = '0;
                        state_nx = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (kif.ENC_LOAD_N || (kif.ENC_BCD != cand)) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        commit   = 1'b1;
                        state_nx = RELEASE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!kif.ENC_LOAD_N) begin
                        cnt_nx = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // CLEAR overrides a coincident commit: no shift and no pulse.
    assign accept = commit && !kif.CLEAR && (digit_cnt < 3'd4);
    assign reject = commit && !kif.CLEAR && (digit_cnt >= 3'd4);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            min_tens  <= '0;
            min_ones  <= '0;
            sec_tens  <= '0;
            sec_ones  <= '0;
            digit_cnt <= '0;
            key_ack   <= 1'b0;
            key_rej   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            cand    <= cand_nx;
            key_ack <= accept;
            key_rej <= reject;
            if (kif.CLEAR) begin
                min_tens  <= '0;
                min_ones  <= '0;
                sec_tens  <= '0;
                sec_ones  <= '0;
                digit_cnt <= '0;
            end else if (accept) begin
                // New digit enters at the seconds end, like a calculator.
                min_tens  <= min_ones;
                min_ones  <= sec_tens;
                sec_tens  <= sec_ones;
                sec_ones  <= cand;
                digit_cnt <= digit_cnt + 3'd1;
            end
        end
    end

`ifdef KEYPAD_BEEP_EN
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    logic [BW-1:0] beep_cnt;
    logic          beep;

    // beep rises with the ACK/REJ pulse; beep_cnt holds the remaining
    // high cycles after the current one.
    always_ff @(posedge CLK) begin
        if (!RESET_N || !kif.ENTRY_EN) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (accept || reject) begin
            beep     <= 1'b1;
            beep_cnt <= BW'(BEEP_CYCLES - 1);
        end else if (beep_cnt != '0) begin
            beep_cnt <= beep_cnt - 1'b1;
        end else begin
            beep <= 1'b0;
        end
    end

    assign kif.BEEP = beep;
`endif

    assign kif.ENC_EN_N  = !kif.ENTRY_EN;
    assign kif.MIN_TENS  = min_tens;
    assign kif.MIN_ONES  = min_ones;
    assign kif.SEC_TENS  = sec_tens;
    assign kif.SEC_ONES  = sec_ones;
    assign kif.DIGIT_CNT = digit_cnt;
    assign kif.TIME_NZ   = |{min_tens, min_ones, sec_tens, sec_ones};
    assign kif.KEY_ACK   = key_ack;
    assign kif.KEY_REJ   = key_rej;
endmodule

// File: tb/tb_keypad_entry_controller.sv
// tb_keypad_entry_controller
//   Directed scenarios followed by randomized keypad activity.  A reference
//   model describes a press as a run of identical low samples (accepted at
//   the (D+1)th) and a release as a run of D high samples.
module tb_keypad_entry_controller;
    localparam int D  = 4;
    localparam int BC = 8;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    keypad_entry_controller_if kif();

    keypad_entry_controller #(.DEBOUNCE_CYCLES(D), .BEEP_CYCLES(BC)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .kif(kif.slave)
    );

    int checks = 0;
    int failures = 0;

    // reference model state
    int   m_d[4];        // [0]=MIN_TENS .. [3]=SEC_ONES
    int   m_n;           // digits entered
    int   m_run;         // identical low samples seen in current press
    int   m_cand;
    bit   m_busy;        // press accepted, waiting for a clean release
    int   m_highs;
    bit   m_ack, m_rej;
    int   m_bl;          // beep cycles remaining including current

    int ack_seen = 0, rej_seen = 0, beep_hi = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit commit;
        m_ack = 0; m_rej = 0; commit = 0;
        if (!RESET_N) begin
            foreach (m_d[i]) m_d[i] = 0;
            m_n = 0; m_run = 0; m_cand = 0; m_busy = 0; m_highs = 0; m_bl = 0;
            return;
        end
        if (!kif.ENTRY_EN) begin
            m_run = 0; m_busy = 0; m_highs = 0;
        end else if (m_busy) begin
            if (kif.ENC_LOAD_N) begin
                m_highs++;
                if (m_highs == D) begin m_busy = 0; m_highs = 0; end
            end else m_highs = 0;
        end else if (!kif.ENC_LOAD_N) begin
            if (m_run > 0 && int'(kif.ENC_BCD) == m_cand) begin
                m_run++;
                if (m_run == D + 1) begin commit = 1; m_run = 0; m_busy = 1; m_highs = 0; end
            end else if (m_run > 0) m_run = 0;
            else begin m_cand = int'(kif.ENC_BCD); m_run = 1; end
        end else m_run = 0;

        if (commit && !kif.CLEAR) begin
            if (m_n < 4) begin
                m_d[0] = m_d[1]; m_d[1] = m_d[2]; m_d[2] = m_d[3]; m_d[3] = m_cand;
                m_n++; m_ack = 1;
            end else m_rej = 1;
        end
        if (kif.CLEAR) begin
            foreach (m_d[i]) m_d[i] = 0;
            m_n = 0;
        end
        if (!kif.ENTRY_EN) m_bl = 0;
        else if (m_ack || m_rej) m_bl = BC;
        else if (m_bl > 0) m_bl--;
    endtask

    task automatic check_all();
        check("min_tens", 8'(kif.MIN_TENS), 8'(m_d[0]));
        check("min_ones", 8'(kif.MIN_ONES), 8'(m_d[1]));
        check("sec_tens", 8'(kif.SEC_TENS), 8'(m_d[2]));
        check("sec_ones", 8'(kif.SEC_ONES), 8'(m_d[3]));
        check("digit_cnt", 8'(kif.DIGIT_CNT), 8'(m_n));
        check("time_nz", 8'(kif.TIME_NZ), 8'((m_d[0] | m_d[1] | m_d[2] | m_d[3]) != 0));
        check("key_ack", 8'(kif.KEY_ACK), 8'(m_ack));
        check("key_rej", 8'(kif.KEY_REJ), 8'(m_rej));
        check("enc_en_n", 8'(kif.ENC_EN_N), 8'(!kif.ENTRY_EN));
`ifdef KEYPAD_BEEP_EN
        check("beep", 8'(kif.BEEP), 8'(m_bl > 0));
`endif
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_all();
        ack_seen += int'(kif.KEY_ACK);
        rej_seen += int'(kif.KEY_REJ);
`ifdef KEYPAD_BEEP_EN
        beep_hi += int'(kif.BEEP);
`endif
    endtask

    task automatic press(input int dig, input int n);
        kif.ENC_BCD = 4'(dig);
        kif.ENC_LOAD_N = 1'b0;
        repeat (n) tick();
    endtask

    task automatic release_key(input int n);
        kif.ENC_LOAD_N = 1'b1;
        repeat (n) tick();
    endtask

    task automatic clear_pulse();
        kif.CLEAR = 1'b1; tick(); kif.CLEAR = 1'b0;
    endtask

    initial begin
        int a0, r0;
        kif.ENTRY_EN = 1'b1; kif.CLEAR = 1'b0; kif.ENC_BCD = 4'd0; kif.ENC_LOAD_N = 1'b1;

        // reset
        RESET_N = 1'b0;
        repeat (2) tick();
        check("rst_digit_cnt", 8'(kif.DIGIT_CNT), 8'd0);
        check("rst_sec_ones", 8'(kif.SEC_ONES), 8'd0);
        check("rst_ack", 8'(kif.KEY_ACK), 8'd0);
        RESET_N = 1'b1;

        // key 5 held 10 cycles: ack on 5th sample, exactly once
        a0 = ack_seen; beep_hi = 0;
        press(5, D);
        check("ack_not_early", 8'(ack_seen - a0), 8'd0);
        press(5, 1);
        check("ack_on_commit", 8'(kif.KEY_ACK), 8'd1);
        press(5, 10 - D - 1);
        release_key(D + 1);
        check("held5_one_ack", 8'(ack_seen - a0), 8'd1);
        check("held5_sec_ones", 8'(kif.SEC_ONES), 8'd5);
        check("held5_cnt", 8'(kif.DIGIT_CNT), 8'd1);
        check("held5_nz", 8'(kif.TIME_NZ), 8'd1);
`ifdef KEYPAD_BEEP_EN
        check("beep_len", 8'(beep_hi), 8'(BC));
`endif

        // 1,2,3,0 then a rejected 7
        clear_pulse();
        foreach (m_d[i]) begin
            press(i == 3 ? 0 : i + 1, D + 2);
            release_key(D + 1);
        end
        check("seq_min_tens", 8'(kif.MIN_TENS), 8'd1);
        check("seq_min_ones", 8'(kif.MIN_ONES), 8'd2);
        check("seq_sec_tens", 8'(kif.SEC_TENS), 8'd3);
        check("seq_sec_ones", 8'(kif.SEC_ONES), 8'd0);
        check("seq_cnt", 8'(kif.DIGIT_CNT), 8'd4);
        a0 = ack_seen; r0 = rej_seen;
        press(7, D + 3);
        release_key(D + 1);
        check("fifth_rej", 8'(rej_seen - r0), 8'd1);
        check("fifth_no_ack", 8'(ack_seen - a0), 8'd0);
        check("fifth_sec_ones", 8'(kif.SEC_ONES), 8'd0);

        // bounce: low 2, high 1, low 2, high
        clear_pulse();
        a0 = ack_seen; r0 = rej_seen;
        press(6, 2); release_key(1); press(6, 2); release_key(3);
        check("bounce_no_ack", 8'(ack_seen - a0), 8'd0);
        check("bounce_no_rej", 8'(rej_seen - r0), 8'd0);
        check("bounce_cnt", 8'(kif.DIGIT_CNT), 8'd0);
        press(6, D + 1);   // back in IDLE: a clean press is taken at once
        check("bounce_then_ack", 8'(ack_seen - a0), 8'd1);
        release_key(D);

        // key 8 held 50, 2-cycle glitch during release
        a0 = ack_seen;
        press(8, 50); release_key(2); press(8, 5); release_key(D + 2);
        check("glitch_one_ack", 8'(ack_seen - a0), 8'd1);
        check("glitch_sec_ones", 8'(kif.SEC_ONES), 8'd8);

        // CLEAR on the commit edge of key 4 after 9,9
        clear_pulse();
        press(9, D + 1); release_key(D);
        press(9, D + 1); release_key(D);
        a0 = ack_seen;
        press(4, D);
        kif.CLEAR = 1'b1; tick(); kif.CLEAR = 1'b0;
        check("clr_commit_cnt", 8'(kif.DIGIT_CNT), 8'd0);
        check("clr_commit_nz", 8'(kif.TIME_NZ), 8'd0);
        check("clr_commit_ack", 8'(ack_seen - a0), 8'd0);
        press(4, 10);
        check("clr_held_no_ack", 8'(ack_seen - a0), 8'd0);
        release_key(D);
        press(4, D + 1);
        check("clr_new_ack", 8'(ack_seen - a0), 8'd1);
        release_key(D);

        // ENTRY_EN dropped mid-debounce
        a0 = ack_seen;
        press(2, 2);
        kif.ENTRY_EN = 1'b0;
        tick();
        check("entry_off_en_n", 8'(kif.ENC_EN_N), 8'd1);
        tick();
        release_key(2);
        kif.ENTRY_EN = 1'b1;
        release_key(2);
        check("entry_off_no_ack", 8'(ack_seen - a0), 8'd0);

        // reset mid-release
        press(3, D + 1); release_key(2);
        RESET_N = 1'b0; tick(); RESET_N = 1'b1;
        check("rst_mid_cnt", 8'(kif.DIGIT_CNT), 8'd0);
        check("rst_mid_sec_ones", 8'(kif.SEC_ONES), 8'd0);
        release_key(D);

        // randomized activity
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            len = int'($urandom_range(1, 8));
            kif.ENTRY_EN = ($urandom_range(0, 29) != 0);
            kif.ENC_BCD  = 4'($urandom_range(0, 9));
            kif.ENC_LOAD_N = $urandom_range(0, 1) == 1;
            for (int k = 0; k < len; k++) begin
                kif.CLEAR = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 9) == 0) kif.ENC_BCD = 4'($urandom_range(0, 9));
                if ($urandom_range(0, 59) == 0) RESET_N = 1'b0;
                tick();
                RESET_N = 1'b1;
            end
        end
        kif.CLEAR = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_entry_controller.md
Name: keypad_entry_controller

Overview:
- Sequences the decimal-to-BCD keypad encoder. It enables the encoder, debounces key presses seen on the encoder's LOAD_N/BCD outputs, and shifts each accepted digit into a 4-digit MM:SS cook-time register.
- Sits between the raw keypad/encoder pair and the cook-timer load logic. It accepts exactly one digit per physical press.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples required for press and for release (use 4 in simulation, 500000 at 50 MHz in synthesis).
BEEP_CYCLES, 8, BEEP pulse length in clocks (used only with KEYPAD_BEEP_EN).

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RESET_N  input  1  reset, synchronous, active-low.
ENTRY_EN  input  1  high = keypad entry permitted (door closed, not cooking).
CLEAR  input  1  synchronous clear of the entered time.
ENC_BCD  input  4  BCD digit from the encoder.
ENC_LOAD_N  input  1  encoder key-valid, active-low.
ENC_EN_N  output  1  encoder enable, active-low.
MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES  output  4 each  entered digits.
DIGIT_CNT  output  3  number of digits entered, 0..4.
TIME_NZ  output  1  high when any digit is nonzero.
KEY_ACK  output  1  one-cycle pulse; a digit was accepted.
KEY_REJ  output  1  one-cycle pulse; a press was rejected because 4 digits were already entered.
BEEP  output  1  present only with KEYPAD_BEEP_EN.

Behaviour:
- Reset (RESET_N=0 at an edge):
  - State goes to IDLE; debounce counter and candidate digit go to 0.
  - All digit outputs, DIGIT_CNT, KEY_ACK, KEY_REJ and BEEP go to 0.
  - Reset has priority over every other input, including mid-debounce and mid-release.
- ENC_EN_N = !ENTRY_EN, combinational.
- TIME_NZ = OR of all 16 digit bits, combinational.
- ENTRY_EN=0: state is forced to IDLE and the counter is cleared. Digits are retained.
- State machine (IDLE, DEBOUNCE, RELEASE):
  - IDLE: if ENC_LOAD_N=0, latch ENC_BCD as the candidate, set counter to 0, go to DEBOUNCE.
  - DEBOUNCE: if ENC_LOAD_N=1 or ENC_BCD differs from the candidate, go to IDLE with no pulse. Otherwise increment the counter.
  - DEBOUNCE commit: on the edge where the counter equals DEBOUNCE_CYCLES-1:
    - If DIGIT_CNT<4: shift MIN_TENS<=MIN_ONES, MIN_ONES<=SEC_TENS, SEC_TENS<=SEC_ONES, SEC_ONES<=candidate; DIGIT_CNT+1; KEY_ACK=1 for one cycle.
    - Else: digits unchanged; KEY_REJ=1 for one cycle.
    - Then go to RELEASE with the counter at 0.
  - RELEASE: count consecutive cycles with ENC_LOAD_N=1. Any ENC_LOAD_N=0 resets the count. At DEBOUNCE_CYCLES consecutive high samples, go to IDLE.
- Latency: the first low sample is taken at edge e0. Digit update and KEY_ACK are visible after edge e(DEBOUNCE_CYCLES). The key must therefore stay stable for DEBOUNCE_CYCLES+1 samples.
- A held key produces exactly one ACK. A new press is accepted only after a debounced release.
- CLEAR:
  - Sets all digits and DIGIT_CNT to 0. The FSM state is unaffected.
  - If CLEAR coincides with a commit, CLEAR wins: digits become 0, KEY_ACK=0, KEY_REJ=0, and the FSM still moves to RELEASE.
- Digit values are not range-checked. Encoder output is 0..9 by construction. SEC_TENS values >5 are passed through to the timer, which normalises them.

Optional Feature:
- Macro: KEYPAD_BEEP_EN.
- Defined:
  - BEEP goes high on the edge of KEY_ACK or KEY_REJ and stays high for BEEP_CYCLES clocks.
  - A new ACK or REJ during a beep restarts the count.
  - Reset and ENTRY_EN=0 force BEEP=0.
- Undefined: the BEEP port and its counter are absent; all other behaviour is identical.

Test Plan:
- Each scenario runs with DEBOUNCE_CYCLES=4.
- Press key 5 (ENC_BCD=5, ENC_LOAD_N=0) held 10 cycles from reset -> single KEY_ACK after the 4th edge following first sample; SEC_ONES=5, DIGIT_CNT=1, TIME_NZ=1.
- Enter 1,2,3,0 with full releases -> MIN_TENS=1, MIN_ONES=2, SEC_TENS=3, SEC_ONES=0, DIGIT_CNT=4. A 5th press of 7 -> KEY_REJ pulse, digits unchanged, no KEY_ACK.
- Bounce: ENC_LOAD_N low 2 cycles, high 1, low 2, then high -> no KEY_ACK or KEY_REJ; FSM back in IDLE; digits unchanged.
- Key 8 held 50 cycles with a 2-cycle high glitch mid-release, then a real release -> exactly one KEY_ACK; SEC_ONES=8.
- CLEAR asserted on the commit edge of key 4 after prior digits 9,9 -> all digits 0, DIGIT_CNT=0, no KEY_ACK; a new key is accepted only after release.
- ENTRY_EN dropped mid-debounce -> ENC_EN_N=1, state IDLE, no pulse. Separately, RESET_N=0 mid-release -> all outputs 0 on the next edge. With KEYPAD_BEEP_EN, each ACK gives BEEP high for exactly 8 cycles.
